// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with built-in prescaler, polarity options,
// ghost blanking, decimal points, digit mask, leading-zero suppression and
// frame-synchronous (tear-free) shadowing of the displayed value.
// Latency: outputs are registered, 1 clk after the (idx,cnt,shadow) state they show.
// Backpressure: none; free-running while en=1, idle and transparent-loading while en=0.
//
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   en              scan enable; 0 parks the scanner at digit 0 with the display dark
//   value           4*N_DIGITS hex nibbles, digit i = value[4i+3:4i]
//   dp              decimal point per digit
//   digit_mask      1 = digit enabled
//   lz_supp         leading-zero suppression enable
//   an              anode drives, one-hot active while a digit is lit
//   sev_out         segments {a,b,c,d,e,f,g}
//   dp_out          decimal point segment
//   frame_done      1-cycle pulse after the last slot of each frame
module sevseg_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter bit AN_ACT_LOW   = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_mask,
    input  logic                    lz_supp,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              sev_out,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Idle levels of the pins in the configured polarity.
    localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [6:0]          SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = SEG_ACT_LOW;
    localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

    // Segment pattern in active-low form (0 = lit), order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [4*N_DIGITS-1:0]  sh_value;
    logic [N_DIGITS-1:0]    sh_dp;
    logic [N_DIGITS-1:0]    sh_mask;
    logic                   sh_lz;

    logic                   slot_end;
    logic                   frame_end;
    logic [N_DIGITS-1:0]    lz_vec;
    logic [3:0]             cur_nib;
    logic [6:0]             cur_seg_lo;

    logic [N_DIGITS-1:0]    an_nxt;
    logic [6:0]             sev_nxt;
    logic                   dp_nxt;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign cur_nib   = sh_value[{idx, 2'b00} +: 4];

    // lz_vec[i]: digit i and every digit above it are zero. Digit 0 is
    // excluded so an all-zero value still shows a single '0'.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (sh_value[4*i +: 4] == 4'h0);
            lz_vec[i]  = zero_above & (i != 0);
        end
    end

    always_comb begin
        cur_seg_lo = seg_decode(cur_nib);
        if (sh_lz && lz_vec[idx]) begin
            cur_seg_lo = 7'h7F;
        end
    end

    // Next output word. The first BLANK_CYCLES of each slot keep everything
    // dark so the previous digit's segments never ghost onto the new anode.
    // A masked digit is fully dark, decimal point included.
    always_comb begin
        an_nxt  = AN_OFF;
        sev_nxt = SEG_OFF;
        dp_nxt  = DP_OFF;
        if (en && (cnt >= CNT_BLANK) && sh_mask[idx]) begin
            an_nxt  = AN_ACT_LOW ? ~(ONE_HOT0 << idx) : (ONE_HOT0 << idx);
            sev_nxt = SEG_ACT_LOW ? cur_seg_lo : ~cur_seg_lo;
            dp_nxt  = sh_dp[idx] ? ~DP_OFF : DP_OFF;
        end
    end

    // Prescaler and digit index. Disabling parks at digit 0, slot start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow copy of the display inputs: follows the inputs while idle, and
    // otherwise only at the frame boundary so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_mask  <= '0;
            sh_lz    <= 1'b0;
        end else if (!en || frame_end) begin
            sh_value <= value;
            sh_dp    <= dp;
            sh_mask  <= digit_mask;
            sh_lz    <= lz_supp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= AN_OFF;
            sev_out    <= SEG_OFF;
            dp_out     <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            sev_out    <= sev_nxt;
            dp_out     <= dp_nxt;
            frame_done <= en && frame_end;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
module tb_sevseg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N * DIV;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [15:0]    value;
    logic [3:0]     dp;
    logic [3:0]     digit_mask;
    logic           lz_supp;

    logic [3:0]     an_lo, an_hi;
    logic [6:0]     sev_lo, sev_hi;
    logic           dp_lo, dp_hi;
    logic           fd_lo, fd_hi;

    int checks = 0;
    int passes = 0;
    logic cmp_on = 1'b0;

    always #5 clk = ~clk;

    sevseg_scan_ctrl #(
        .N_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK),
        .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp),
        .digit_mask(digit_mask), .lz_supp(lz_supp),
        .an(an_lo), .sev_out(sev_lo), .dp_out(dp_lo), .frame_done(fd_lo)
    );

    sevseg_scan_ctrl #(
        .N_DIGITS(N), .SCAN_DIV(DIV), .BLANK_CYCLES(BLANK),
        .AN_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp),
        .digit_mask(digit_mask), .lz_supp(lz_supp),
        .an(an_hi), .sev_out(sev_hi), .dp_out(dp_hi), .frame_done(fd_hi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // ---------------- reference model ----------------
    // The scan is a position within the frame: slot = pos / DIV, phase = pos % DIV.
    // Expectations are kept polarity-free: e_slot = lit digit (-1 = none),
    // e_seg_lo = segment pattern with 0 = lit, e_dp = decimal point lit.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

    int          pos = 0;
    int          slot, phase;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0, m_mask = '0;
    logic        m_lz = 1'b0;
    logic [3:0]  nib;
    int          e_slot = -1;
    logic [6:0]  e_seg_lo = 7'h7F;
    logic        e_dp = 1'b0;
    logic        e_fd = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; m_val = '0; m_dp = '0; m_mask = '0; m_lz = 1'b0;
            e_slot = -1; e_seg_lo = 7'h7F; e_dp = 1'b0; e_fd = 1'b0;
        end else if (!en) begin
            e_slot = -1; e_seg_lo = 7'h7F; e_dp = 1'b0; e_fd = 1'b0;
            pos = 0;
            m_val = value; m_dp = dp; m_mask = digit_mask; m_lz = lz_supp;
        end else begin
            slot  = pos / DIV;
            phase = pos % DIV;
            e_slot = -1; e_seg_lo = 7'h7F; e_dp = 1'b0;
            if (phase >= BLANK && m_mask[slot]) begin
                e_slot = slot;
                e_dp   = m_dp[slot];
                nib    = 4'(m_val >> (4 * slot));
                if (!(m_lz && slot > 0 && (m_val >> (4 * slot)) == 16'h0))
                    e_seg_lo = SEG_TAB[nib];
            end
            e_fd = (pos == FRAME - 1);
            if (e_fd) begin
                m_val = value; m_dp = dp; m_mask = digit_mask; m_lz = lz_supp;
            end
            pos = (pos + 1) % FRAME;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [3:0] one4 = 4'b0001;
    logic [3:0] x_oh, x_an_lo;
    logic [6:0] x_seg_hi;
    logic       x_dp_lo;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmp_on) begin
                x_oh     = (e_slot < 0) ? 4'b0000 : (one4 << e_slot);
                x_an_lo  = ~x_oh;
                x_seg_hi = ~e_seg_lo;
                x_dp_lo  = ~e_dp;
                chk("an_lo", an_lo, x_an_lo);
                chk("sev_lo", sev_lo, e_seg_lo);
                chk("dp_lo", dp_lo, x_dp_lo);
                chk("fd_lo", fd_lo, e_fd);
                chk("an_hi", an_hi, x_oh);
                chk("sev_hi", sev_hi, x_seg_hi);
                chk("dp_hi", dp_hi, e_dp);
                chk("fd_hi", fd_hi, e_fd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        rst_n = 1'b0; en = 1'b0; value = 16'h1234; dp = 4'b0000;
        digit_mask = 4'b1111; lz_supp = 1'b0;
        cmp_on = 1'b1;
        tick(3);
        chk("rst_an_lo", an_lo, 4'b1111);
        chk("rst_sev_lo", sev_lo, 7'b1111111);
        chk("rst_dp_lo", dp_lo, 1'b1);
        chk("rst_fd", fd_lo, 1'b0);
        chk("rst_an_hi", an_hi, 4'b0000);
        rst_n = 1'b1;
        tick(2);                    // idle cycles load the shadow with 1234
        en = 1'b1;

        // Edges counted from enable: E1 is the first enabled edge.
        tick(1);                    // E1
        chk("blank0_an", an_lo, 4'b1111);
        tick(2);                    // E3
        chk("slot0_an", an_lo, 4'b1110);
        chk("slot0_sev", sev_lo, 7'b1001100);  // nibble 0 = '4'
        tick(8);                    // E11
        chk("slot1_an", an_lo, 4'b1101);
        chk("slot1_sev", sev_lo, 7'b0000110);  // '3'
        tick(21);                   // E32
        chk("frame_done_hi", fd_lo, 1'b1);
        tick(1);                    // E33
        chk("frame_done_lo", fd_lo, 1'b0);

        tick(17);                   // E50, scanning digit 2
        value = 16'hABCD;
        tick(2);                    // E52
        chk("tear_an", an_lo, 4'b1011);
        chk("tear_sev", sev_lo, 7'b0010010);   // still '2' from 1234
        tick(15);                   // E67, next frame slot 0
        chk("newval_sev", sev_lo, 7'b1000010); // 'd'

        value = 16'h0050; lz_supp = 1'b1;
        tick(32);                   // E99
        chk("lz_d0_sev", sev_lo, 7'b0000001);
        tick(8);                    // E107
        chk("lz_d1_sev", sev_lo, 7'b0100100);
        tick(8);                    // E115
        chk("lz_d2_an", an_lo, 4'b1011);
        chk("lz_d2_sev", sev_lo, 7'b1111111);
        tick(8);                    // E123
        chk("lz_d3_an", an_lo, 4'b0111);
        chk("lz_d3_sev", sev_lo, 7'b1111111);

        // dp set on masked digit 0 (must stay dark) and on live digit 1.
        digit_mask = 4'b1010; dp = 4'b0011; lz_supp = 1'b0;
        tick(8);                    // E131
        chk("mask_d0_an", an_lo, 4'b1111);
        chk("mask_d0_dp", dp_lo, 1'b1);
        tick(8);                    // E139
        chk("mask_d1_an", an_lo, 4'b1101);
        chk("mask_d1_dp", dp_lo, 1'b0);

        tick(18);                   // E157: state now digit 3, cnt 5
        en = 1'b0; digit_mask = 4'b1111;
        tick(1);                    // E158
        chk("dis_an", an_lo, 4'b1111);
        chk("dis_sev", sev_lo, 7'b1111111);
        tick(1);
        en = 1'b1;
        tick(1);
        chk("reen_blank", an_lo, 4'b1111);
        tick(2);
        chk("reen_an", an_lo, 4'b1110);
        chk("reen_sev", sev_lo, 7'b0000001);

        tick(2);                    // digit 0 lit mid-slot
        #1 rst_n = 1'b0;
        #1;
        chk("arst_an_lo", an_lo, 4'b1111);
        chk("arst_sev_lo", sev_lo, 7'b1111111);
        chk("arst_an_hi", an_hi, 4'b0000);
        chk("arst_sev_hi", sev_hi, 7'b0000000);
        value = 16'h0008; en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        en = 1'b1;
        tick(3);
        chk("hi_eight_sev", sev_hi, 7'b1111111);
        chk("hi_eight_an", an_hi, 4'b0001);
        chk("hi_eight_dp", dp_hi, 1'b1);
        chk("lo_eight_sev", sev_lo, 7'b0000000);

        tick(40);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
